// File: rtl/audio_frame_pacer.sv
// Paces sample pairs from the sound core into the I2S transmitter, one pair per audio frame.
// Latency: a stored pair appears on APSDATA_*_o one cycle after the frame tick that pops it.
// Backpressure: none upstream; writes to a full buffer are dropped and flagged, empty ticks repeat data and flag.
module audio_frame_pacer #(
  parameter int I2S_DATA_BITS      = 24,
  parameter int FIFO_DEPTH         = 8,
  parameter int MCLK_FRAME_DIVIDER = 512,
  parameter int PREFILL_LEVEL      = 4
) (
  input  logic                            AMCLK_i,
  input  logic                            reset_i,
  input  logic [I2S_DATA_BITS-1:0]        SAMPLE_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0]        SAMPLE_RIGHT_i,
  input  logic                            SAMPLE_VALID_i,
  input  logic                            CLR_FLAGS_i,
  output logic [I2S_DATA_BITS-1:0]        APSDATA_LEFT_o,
  output logic [I2S_DATA_BITS-1:0]        APSDATA_RIGHT_o,
  output logic                            APDATA_VALID_o,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_LEVEL_o,
  output logic                            UNDERRUN_o,
  output logic                            OVERFLOW_o
);

  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int LVL_W         = PTR_W + 1;
  localparam int MCLK_DIV_BITS = $clog2(MCLK_FRAME_DIVIDER);

  typedef enum logic {
    ST_PREFILL = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [MCLK_DIV_BITS-1:0]  frame_cnt;

  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [LVL_W-1:0]          level;

  logic [I2S_DATA_BITS-1:0]  mem_left  [FIFO_DEPTH];
  logic [I2S_DATA_BITS-1:0]  mem_right [FIFO_DEPTH];

  logic                      tick;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      pop;
  logic                      underrun_evt;
  logic                      wr_ok;
  logic                      wr_drop;

  // State register: PREFILL until enough pairs are buffered, RUN while pacing frames.
  always_ff @(posedge AMCLK_i) begin
    if (reset_i) begin
      state <= ST_PREFILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave PREFILL once the level target is met, fall back on an empty tick.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_PREFILL: begin
        if (level >= LVL_W'(PREFILL_LEVEL)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (underrun_evt) begin
          state_next = ST_PREFILL;
        end
      end
      default: state_next = ST_PREFILL;
    endcase
  end

  // Output/decode logic: frame tick, pop/underrun decisions and write acceptance.
  // A write into a full buffer still succeeds when a pop frees the head slot in the same cycle.
  always_comb begin
    tick         = (state == ST_RUN) && (frame_cnt == '0);
    fifo_empty   = (level == '0);
    fifo_full    = (level == LVL_W'(FIFO_DEPTH));
    pop          = tick && !fifo_empty;
    underrun_evt = tick && fifo_empty;
    wr_ok        = SAMPLE_VALID_i && (!fifo_full || pop);
    wr_drop      = SAMPLE_VALID_i && fifo_full && !pop;
  end

  // Frame counter: parked at 0 outside RUN so the first RUN cycle is a tick; wraps naturally.
  always_ff @(posedge AMCLK_i) begin
    if (reset_i) begin
      frame_cnt <= '0;
    end else if ((state == ST_RUN) && (state_next == ST_RUN)) begin
      frame_cnt <= frame_cnt + MCLK_DIV_BITS'(1);
    end else begin
      frame_cnt <= '0;
    end
  end

  // Sample storage: no reset needed, occupancy is tracked by the pointers and level.
  // When full with a simultaneous pop, wr_ptr equals rd_ptr; the head is read before being overwritten.
  always_ff @(posedge AMCLK_i) begin
    if (wr_ok) begin
      mem_left[wr_ptr]  <= SAMPLE_LEFT_i;
      mem_right[wr_ptr] <= SAMPLE_RIGHT_i;
    end
  end

  // Pointer and level bookkeeping; pointers wrap modulo FIFO_DEPTH by width.
  always_ff @(posedge AMCLK_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({wr_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Transmitter outputs: data loads on a pop, holds on underrun; valid pulses for every tick.
  always_ff @(posedge AMCLK_i) begin
    if (reset_i) begin
      APSDATA_LEFT_o  <= '0;
      APSDATA_RIGHT_o <= '0;
      APDATA_VALID_o  <= 1'b0;
    end else begin
      APDATA_VALID_o <= tick;
      if (pop) begin
        APSDATA_LEFT_o  <= mem_left[rd_ptr];
        APSDATA_RIGHT_o <= mem_right[rd_ptr];
      end
    end
  end

  // Sticky flags: a set event in the same cycle takes priority over a clear request.
  always_ff @(posedge AMCLK_i) begin
    if (reset_i) begin
      UNDERRUN_o <= 1'b0;
      OVERFLOW_o <= 1'b0;
    end else begin
      if (underrun_evt) begin
        UNDERRUN_o <= 1'b1;
      end else if (CLR_FLAGS_i) begin
        UNDERRUN_o <= 1'b0;
      end
      if (wr_drop) begin
        OVERFLOW_o <= 1'b1;
      end else if (CLR_FLAGS_i) begin
        OVERFLOW_o <= 1'b0;
      end
    end
  end

  assign FIFO_LEVEL_o = level;

endmodule

// File: tb/tb_audio_frame_pacer.sv
// Directed bench for audio_frame_pacer with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected values are hand-derived frame timings and sample sequences.
module tb_audio_frame_pacer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        s_valid;
  logic        clr;
  logic [23:0] o_left;
  logic [23:0] o_right;
  logic        o_valid;
  logic [3:0]  o_level;
  logic        o_underrun;
  logic        o_overflow;

  int vectors     = 0;
  int miscompares = 0;
  int back_to_back = 0;
  logic prev_valid = 1'b0;

  audio_frame_pacer #(
    .I2S_DATA_BITS(24),
    .FIFO_DEPTH(8),
    .MCLK_FRAME_DIVIDER(512),
    .PREFILL_LEVEL(4)
  ) dut (
    .AMCLK_i(clk),
    .reset_i(rst),
    .SAMPLE_LEFT_i(s_left),
    .SAMPLE_RIGHT_i(s_right),
    .SAMPLE_VALID_i(s_valid),
    .CLR_FLAGS_i(clr),
    .APSDATA_LEFT_o(o_left),
    .APSDATA_RIGHT_o(o_right),
    .APDATA_VALID_o(o_valid),
    .FIFO_LEVEL_o(o_level),
    .UNDERRUN_o(o_underrun),
    .OVERFLOW_o(o_overflow)
  );

  always #5 clk = ~clk;

  // Track any two consecutive valid cycles.
  always @(negedge clk) begin
    if (o_valid && prev_valid) back_to_back = back_to_back + 1;
    prev_valid = o_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    cyc(1);
    s_valid = 1'b0;
  endtask

  // Advance until a valid pulse is seen (bounded); returns cycles taken.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!o_valid && n < 2000);
    check({tag, "_seen"}, {31'b0, o_valid}, 32'h1);
  endtask

  initial begin
    int n;
    int pulses;

    rst = 1'b1; s_left = '0; s_right = '0; s_valid = 1'b0; clr = 1'b0;
    cyc(1);
    check("rst_left",  o_left,     32'h0);
    check("rst_right", o_right,    32'h0);
    check("rst_valid", o_valid,    32'h0);
    check("rst_level", o_level,    32'h0);
    check("rst_unf",   o_underrun, 32'h0);
    check("rst_ovf",   o_overflow, 32'h0);
    rst = 1'b0;

    // Prefill four pairs, then drain them at the frame rate and underrun.
    for (int k = 1; k <= 4; k++) push(24'(k), 24'h100000 + 24'(k));
    check("pf_level", o_level, 32'd4);
    cyc(1);
    check("run_entry_valid", o_valid, 32'h0);
    check("run_entry_level", o_level, 32'd4);
    cyc(1);
    check("p1_valid", o_valid, 32'h1);
    check("p1_left",  o_left,  32'h000001);
    check("p1_right", o_right, 32'h100001);
    check("p1_level", o_level, 32'd3);
    cyc(1);
    check("p1_pulse_width", o_valid, 32'h0);
    cyc(510);
    check("p2_early", o_valid, 32'h0);
    cyc(1);
    check("p2_valid", o_valid, 32'h1);
    check("p2_left",  o_left,  32'h000002);
    check("p2_level", o_level, 32'd2);
    wait_valid("p3", n);
    check("p3_gap",   n,       32'd512);
    check("p3_left",  o_left,  32'h000003);
    check("p3_level", o_level, 32'd1);
    wait_valid("p4", n);
    check("p4_left",  o_left,     32'h000004);
    check("p4_level", o_level,    32'd0);
    check("p4_unf",   o_underrun, 32'h0);
    wait_valid("p5", n);
    check("p5_gap",   n,          32'd512);
    check("p5_left",  o_left,     32'h000004);
    check("p5_right", o_right,    32'h100004);
    check("p5_unf",   o_underrun, 32'h1);
    check("p5_level", o_level,    32'd0);
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc(1);
      if (o_valid) pulses++;
    end
    check("after_unf_pulses", pulses, 32'd0);

    // Ten back-to-back writes: RUN starts after four, the tick pops pair 1 during the burst,
    // so the buffer ends holding pairs 2..9 and pair 10 is dropped.
    for (int k = 1; k <= 10; k++) push(24'h10 + 24'(k), 24'h200000 + 24'(k));
    check("burst_level", o_level,    32'd8);
    check("burst_ovf",   o_overflow, 32'h1);
    check("burst_unf",   o_underrun, 32'h1);

    // Flag clearing, then clear racing an overflow write.
    clr = 1'b1;
    cyc(1);
    check("clr_ovf", o_overflow, 32'h0);
    check("clr_unf", o_underrun, 32'h0);
    push(24'h77, 24'h300077);
    check("clr_race_ovf",   o_overflow, 32'h1);
    check("clr_race_level", o_level,    32'd8);
    cyc(1);
    clr = 1'b0;
    check("clr_again_ovf", o_overflow, 32'h0);

    // Write on the tick edge while full: accepted, no overflow.
    cyc(504);
    check("pre_tick_valid", o_valid, 32'h0);
    push(24'h55, 24'h300055);
    check("tickwr_valid", o_valid,    32'h1);
    check("tickwr_left",  o_left,     32'h000012);
    check("tickwr_level", o_level,    32'd8);
    check("tickwr_ovf",   o_overflow, 32'h0);
    for (int k = 3; k <= 9; k++) begin
      wait_valid("seq", n);
      check("seq_gap",  n,      32'd512);
      check("seq_left", o_left, 32'h10 + 32'(k));
    end
    wait_valid("eighth", n);
    check("eighth_left",  o_left,  32'h000055);
    check("eighth_right", o_right, 32'h300055);
    check("eighth_level", o_level, 32'd0);

    // Reset during RUN with five pairs buffered.
    for (int k = 1; k <= 5; k++) push(24'h40 + 24'(k), 24'h400040 + 24'(k));
    check("pre_rst_level", o_level, 32'd5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_left",  o_left,     32'h0);
    check("mid_rst_right", o_right,    32'h0);
    check("mid_rst_valid", o_valid,    32'h0);
    check("mid_rst_level", o_level,    32'h0);
    check("mid_rst_unf",   o_underrun, 32'h0);
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (o_valid) pulses++;
    end
    check("post_rst_pulses", pulses, 32'd0);
    for (int k = 1; k <= 4; k++) push(24'h60 + 24'(k), 24'h400060 + 24'(k));
    wait_valid("refill", n);
    check("refill_lat",   n,       32'd2);
    check("refill_left",  o_left,  32'h000061);
    check("refill_right", o_right, 32'h400061);
    check("refill_level", o_level, 32'd3);

    cyc(2);
    check("no_back_to_back", back_to_back, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
